// File: rtl/slt_pkg.sv
// Shared types and constants for the iterative signed less-than block.
package slt_pkg;

  localparam int WIRE_DEFAULT  = 32;
  localparam int DIGIT_DEFAULT = 4;

  // Result word: the comparison lands in this bit, every other bit reads zero
  localparam int RES_LT_BIT = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } slt_state_e;

endpackage

// File: rtl/slt_digit_cmp.sv
// Combinational unsigned comparator for one DIGIT-wide slice.
module slt_digit_cmp #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  output logic             lt,
  output logic             eq
);

  assign lt = (a < b);
  assign eq = (a == b);

endmodule

// File: rtl/slt_iter.sv
// Iterative signed A<B, one digit per cycle, MSB digit first.
// Define SLT_ITER_EARLY_EXIT_EN to finish as soon as the result is decided.
module slt_iter
  import slt_pkg::*;
#(
  parameter int WIRE  = WIRE_DEFAULT,
  parameter int DIGIT = DIGIT_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [WIRE-1:0] datain_A,
  input  logic [WIRE-1:0] datain_B,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [WIRE-1:0] out
);

  localparam int N     = WIRE / DIGIT;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  slt_state_e       state_q, state_d;
  logic [WIRE-1:0]  a_q, b_q;
  logic [IDX_W-1:0] idx_q;
  logic             decided_q, lt_q;
  logic [WIRE-1:0]  out_q;

  logic [DIGIT-1:0] digit_a, digit_b;
  logic             dig_lt, dig_eq;
  logic             first_digit, last_digit, sign_diff;
  logic             decide_now, lt_now, lt_final, run_done;
  logic [WIRE-1:0]  res_word;

  // Operands shift left each RUN cycle, so the digit under test is always on top
  assign digit_a = a_q[WIRE-1 -: DIGIT];
  assign digit_b = b_q[WIRE-1 -: DIGIT];

  slt_digit_cmp #(.DIGIT(DIGIT)) u_digit_cmp (
    .a  (digit_a),
    .b  (digit_b),
    .lt (dig_lt),
    .eq (dig_eq)
  );

  assign first_digit = (idx_q == '0);
  assign last_digit  = (idx_q == LAST_IDX);

  // Differing signs settle the answer on the first digit, before any unsigned compare
  always_comb begin
    sign_diff  = first_digit && (a_q[WIRE-1] != b_q[WIRE-1]);
    lt_now     = sign_diff ? a_q[WIRE-1] : dig_lt;
    decide_now = !decided_q && (sign_diff || !dig_eq);
    if (decided_q)
      lt_final = lt_q;
    else if (decide_now)
      lt_final = lt_now;
    else
      lt_final = 1'b0;
    res_word             = '0;
    res_word[RES_LT_BIT] = lt_final;
  end

  always_comb begin
    run_done = last_digit;
`ifdef SLT_ITER_EARLY_EXIT_EN
    if (decide_now)
      run_done = 1'b1;
`endif
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid)
          state_d = RUN;
      end
      RUN: begin
        if (run_done)
          state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // The decided result is parked in lt_q until the fixed-latency exit comes round
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      idx_q     <= '0;
      decided_q <= 1'b0;
      lt_q      <= 1'b0;
      out_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q       <= datain_A;
            b_q       <= datain_B;
            idx_q     <= '0;
            decided_q <= 1'b0;
            lt_q      <= 1'b0;
          end
        end
        RUN: begin
          a_q <= a_q << DIGIT;
          b_q <= b_q << DIGIT;
          if (!last_digit)
            idx_q <= idx_q + IDX_W'(1);
          if (decide_now) begin
            decided_q <= 1'b1;
            lt_q      <= lt_now;
          end
          if (run_done)
            out_q <= res_word;
        end
        default: ;
      endcase
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_slt_iter.sv
// Randomized and directed bench for slt_iter against a plain signed-compare model.
// Expected latency follows SLT_ITER_EARLY_EXIT_EN when it is defined.
module tb_slt_iter;

  localparam int WIRE  = 32;
  localparam int DIGIT = 4;
  localparam int N     = WIRE / DIGIT;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            out_ready = 1'b0;
  logic [WIRE-1:0] datain_A = '0;
  logic [WIRE-1:0] datain_B = '0;
  logic            in_ready;
  logic            out_valid;
  logic [WIRE-1:0] out;

  int checks = 0;
  int errors = 0;

  slt_iter #(.WIRE(WIRE), .DIGIT(DIGIT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .datain_A  (datain_A),
    .datain_B  (datain_B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [WIRE-1:0] obs, input logic [WIRE-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIRE-1:0] model_out(input logic [WIRE-1:0] a, input logic [WIRE-1:0] b);
    return ($signed(a) < $signed(b)) ? WIRE'(1) : WIRE'(0);
  endfunction

  function automatic int model_latency(input logic [WIRE-1:0] a, input logic [WIRE-1:0] b);
`ifdef SLT_ITER_EARLY_EXIT_EN
    longint unsigned mask;
    longint unsigned ua, ub;
    mask = (64'd1 << DIGIT) - 64'd1;
    ua   = 64'(a);
    ub   = 64'(b);
    if (a[WIRE-1] != b[WIRE-1])
      return 1;
    for (int d = 1; d <= N; d++) begin
      if (((ua >> (WIRE - d * DIGIT)) & mask) != ((ub >> (WIRE - d * DIGIT)) & mask))
        return d;
    end
    return N;
`else
    if (a == b)
      return N;
    return N;
`endif
  endfunction

  task automatic apply_stimulus(input logic [WIRE-1:0] a, input logic [WIRE-1:0] b, input int hold);
    logic [WIRE-1:0] exp_out;
    logic [WIRE-1:0] prev_out;
    int lat;
    exp_out = model_out(a, b);
    @(negedge clk);
    check_output("ready_before_accept", WIRE'(in_ready), WIRE'(1));
    prev_out = out;
    in_valid = 1'b1;
    datain_A = a;
    datain_B = b;
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    while (!out_valid && lat < 3 * N) begin
      if (in_ready !== 1'b0 || out !== prev_out)
        check_output("run_ready_or_out_held", {in_ready, out[WIRE-2:0]}, {1'b0, prev_out[WIRE-2:0]});
      in_valid = 1'($urandom);
      datain_A = $urandom;
      datain_B = $urandom;
      @(negedge clk);
      lat++;
    end
    check_output("latency", WIRE'(lat), WIRE'(model_latency(a, b)));
    check_output("result", out, exp_out);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom);
      datain_A = $urandom;
      datain_B = $urandom;
      @(negedge clk);
      check_output("done_hold_valid", WIRE'(out_valid), WIRE'(1));
      check_output("done_hold_out", out, exp_out);
      check_output("done_hold_ready", WIRE'(in_ready), WIRE'(0));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_output("idle_valid", WIRE'(out_valid), WIRE'(0));
    check_output("idle_ready", WIRE'(in_ready), WIRE'(1));
    check_output("idle_out_held", out, exp_out);
  endtask

  initial begin
    logic [WIRE-1:0] ra, rb;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_output("reset_ready", WIRE'(in_ready), WIRE'(1));
    check_output("reset_valid", WIRE'(out_valid), WIRE'(0));
    check_output("reset_out", out, '0);
    @(negedge clk);
    rst_n = 1'b1;

    apply_stimulus(32'd5, 32'd7, 0);
    apply_stimulus(32'hFFFF_FFFF, 32'h0000_0000, 1);
    apply_stimulus(32'h8000_0000, 32'h8000_0000, 0);
    apply_stimulus(32'h7FFF_FFFF, 32'h8000_0000, 5);
    apply_stimulus(32'h8000_0000, 32'h7FFF_FFFF, 0);
    apply_stimulus(32'd7, 32'd5, 2);
    apply_stimulus(32'hFFFF_FFF0, 32'hFFFF_FFF0, 0);

    // Abort mid-RUN: the pending result must never surface
    @(negedge clk);
    in_valid = 1'b1;
    datain_A = 32'h1234_5678;
    datain_B = 32'h1234_5679;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_output("abort_valid", WIRE'(out_valid), WIRE'(0));
    check_output("abort_out", out, '0);
    check_output("abort_ready", WIRE'(in_ready), WIRE'(1));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2 * N; i++) begin
      @(negedge clk);
      check_output("abort_no_stale", WIRE'(out_valid), WIRE'(0));
    end

    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 4))
        0: ra = 32'h8000_0000;
        1: ra = 32'h7FFF_FFFF;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: rb = 32'h8000_0000;
        1: rb = 32'h7FFF_FFFF;
        2: rb = ra;
        3: rb = ra ^ (32'd1 << $urandom_range(0, WIRE - 2));
        default: rb = $urandom;
      endcase
      apply_stimulus(ra, rb, $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
